// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the Memory port arbiter.
package mem_arb_pkg;

    localparam int SIZE     = 32;
    localparam int MEM_ROWS = 64;
    localparam int NUM_REQ  = 4;
    localparam int AW       = $clog2(MEM_ROWS);
    localparam int IW       = $clog2(NUM_REQ);

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   addr;
        logic [SIZE-1:0] wdata;
        logic [IW-1:0]   id;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    int idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        // Scanning from the farthest offset down lets the nearest requester overwrite.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant          = '0;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
                grant_valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one write and one combinational read Memory port;
// accepted requests pass a one-entry access stage, reads return in order with a tag.
module mem_port_arbiter
    import mem_arb_pkg::mem_req_t;
#(
    parameter  int SIZE     = mem_arb_pkg::SIZE,
    parameter  int MEM_ROWS = mem_arb_pkg::MEM_ROWS,
    parameter  int NUM_REQ  = mem_arb_pkg::NUM_REQ,
    localparam int AW       = $clog2(MEM_ROWS),
    localparam int IW       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0][AW-1:0]    req_addr,
    input  logic [NUM_REQ-1:0][SIZE-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          resp_valid,
    output logic [IW-1:0]                 resp_id,
    output logic [SIZE-1:0]               resp_rdata,
    output logic                          EnWrite,
    output logic [AW-1:0]                 write_addr,
    output logic [SIZE-1:0]               write_data,
    output logic [AW-1:0]                 read_addr,
    input  logic [SIZE-1:0]               read_data
);

    if ((1 << AW) != MEM_ROWS) begin : g_bad_rows
        $error("MEM_ROWS must be a power of two");
    end
    if (NUM_REQ < 2) begin : g_bad_req
        $error("NUM_REQ must be at least 2");
    end
    if (SIZE != mem_arb_pkg::SIZE || MEM_ROWS != mem_arb_pkg::MEM_ROWS ||
        NUM_REQ != mem_arb_pkg::NUM_REQ) begin : g_bad_pkg
        $error("parameters must match mem_arb_pkg, which sizes mem_req_t");
    end

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               stage_valid_q, stage_valid_d;
    mem_req_t           stage_q, stage_d;
    logic               resp_valid_q, resp_valid_d;
    logic [IW-1:0]      resp_id_q, resp_id_d;
    logic [SIZE-1:0]    resp_rdata_q, resp_rdata_d;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               grant_valid;
    logic               stage_wr, stage_rd;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req         (req),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign ack        = rst_n ? grant : '0;
    assign stage_wr   = stage_valid_q & stage_q.we;
    assign stage_rd   = stage_valid_q & ~stage_q.we;
    assign EnWrite    = stage_wr;
    assign write_addr = stage_wr ? stage_q.addr  : '0;
    assign write_data = stage_wr ? stage_q.wdata : '0;
    assign read_addr  = stage_rd ? stage_q.addr  : '0;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_rdata = resp_rdata_q;

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        stage_valid_d = grant_valid;
        stage_d       = stage_q;
        resp_valid_d  = stage_rd;
        resp_id_d     = resp_id_q;
        resp_rdata_d  = resp_rdata_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            stage_d  = '{we:    req_we[grant_idx],
                         addr:  req_addr[grant_idx],
                         wdata: req_wdata[grant_idx],
                         id:    grant_idx};
        end
        if (stage_rd) begin
            resp_id_d    = stage_q.id;
            resp_rdata_d = read_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            stage_valid_q <= 1'b0;
            stage_q       <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_rdata_q  <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            stage_valid_q <= stage_valid_d;
            stage_q       <= stage_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_rdata_q  <= resp_rdata_d;
        end
    end

    // A pending request must stay asserted with unchanged fields until acked.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_proto
        a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
            (req[g] && !ack[g]) |=> (req[g] && $stable(req_we[g]) &&
                                     $stable(req_addr[g]) && $stable(req_wdata[g])))
            else $error("requester %0d dropped or changed its request before ack", g);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against an in-order grant/Memory model.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req;
    logic [N-1:0]       req_we;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_wdata;
    logic [N-1:0]       ack;
    logic               resp_valid;
    logic [1:0]         resp_id;
    logic [DW-1:0]      resp_rdata;
    logic               EnWrite;
    logic [AW-1:0]      write_addr;
    logic [DW-1:0]      write_data;
    logic [AW-1:0]      read_addr;
    logic [DW-1:0]      read_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem     [64] = '{default: '0};
    logic [DW-1:0] ref_mem [64] = '{default: '0};

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_rdata (resp_rdata),
        .EnWrite    (EnWrite),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (read_addr),
        .read_data  (read_data)
    );

    assign read_data = mem[read_addr];
    always @(posedge clk) if (EnWrite) mem[write_addr] <= write_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: requests take effect in grant order; a grant sits in the stage one
    // cycle, a read returns the next cycle with the Memory contents at that point.
    int            m_ptr = 0;
    int            win;
    logic [N-1:0]  exp_ack;
    logic          s1_v = 1'b0, s1_we = 1'b0;
    logic [AW-1:0] s1_addr = '0;
    logic [DW-1:0] s1_wdata = '0;
    int            s1_id = 0;
    logic          s2_v = 1'b0;
    int            e_id = 0;
    logic [DW-1:0] e_rd = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ptr = 0; s1_v = 1'b0; s2_v = 1'b0; e_id = 0; e_rd = '0;
            chk("rst_ack",   64'(ack), 64'(0));
            chk("rst_en",    64'(EnWrite), 64'(0));
            chk("rst_rv",    64'(resp_valid), 64'(0));
            chk("rst_id",    64'(resp_id), 64'(0));
            chk("rst_rdata", 64'(resp_rdata), 64'(0));
        end else begin
            win = -1;
            for (int k = 0; k < N; k++)
                if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            exp_ack = '0;
            if (win >= 0) exp_ack[win] = 1'b1;
            chk("ack",        64'(ack), 64'(exp_ack));
            chk("en_write",   64'(EnWrite), 64'(s1_v && s1_we));
            chk("write_addr", 64'(write_addr), 64'((s1_v && s1_we) ? s1_addr : '0));
            chk("write_data", 64'(write_data), 64'((s1_v && s1_we) ? s1_wdata : '0));
            chk("read_addr",  64'(read_addr), 64'((s1_v && !s1_we) ? s1_addr : '0));
            chk("resp_valid", 64'(resp_valid), 64'(s2_v));
            chk("resp_id",    64'(resp_id), 64'(e_id));
            chk("resp_rdata", 64'(resp_rdata), 64'(e_rd));
            s2_v = s1_v && !s1_we;
            if (s1_v) begin
                if (s1_we) ref_mem[s1_addr] = s1_wdata;
                else begin e_id = s1_id; e_rd = ref_mem[s1_addr]; end
            end
            s1_v = (win >= 0);
            if (win >= 0) begin
                s1_we = req_we[win]; s1_addr = req_addr[win];
                s1_wdata = req_wdata[win]; s1_id = win;
                m_ptr = (win + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic on, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = on; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d;
    endtask

    task automatic do_reset();
        tick(); rst_n = 1'b0; req = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        logic [N-1:0] a;
        for (int c = 0; c < 16 && req != '0; c++) begin
            at_neg(); a = ack; tick();
            req = req & ~a;
        end
        chk("drain_done", 64'(req), 64'(0));
    endtask

    logic [N-1:0] a_seen;
    int           n_wait;
    logic         got;

    initial begin
        rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        at_neg();
        chk("t0_ack", 64'(ack), 64'(0));
        chk("t0_rv", 64'(resp_valid), 64'(0));
        chk("t0_rdata", 64'(resp_rdata), 64'(0));
        tick(); rst_n = 1'b1;

        // Requester 2 writes 5 then reads it back.
        tick(); set_req(2, 1, 1, 5, 32'hDEADBEEF);
        at_neg(); chk("t1_ack_c0", 64'(ack), 64'b0100);
        tick(); set_req(2, 1, 0, 5, 0);
        at_neg(); chk("t1_ack_c1", 64'(ack), 64'b0100);
        chk("t1_en_c1", 64'(EnWrite), 64'(1));
        chk("t1_waddr_c1", 64'(write_addr), 64'(5));
        chk("t1_wdata_c1", 64'(write_data), 64'hDEADBEEF);
        tick(); set_req(2, 0, 0, 0, 0);
        at_neg(); chk("t1_raddr_c2", 64'(read_addr), 64'(5));
        tick();
        at_neg(); chk("t1_rv_c3", 64'(resp_valid), 64'(1));
        chk("t1_id_c3", 64'(resp_id), 64'(2));
        chk("t1_rdata_c3", 64'(resp_rdata), 64'hDEADBEEF);

        // All four read continuously from reset.
        do_reset();
        tick();
        for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'(i), 0);
        for (int c = 0; c < 8; c++) begin
            if (c >= 1) begin
                tick();
                if (c >= 5) set_req(c - 5, 0, 0, 0, 0);
            end
            at_neg();
            chk("t2_ack_order", 64'(ack), 64'(1) << (c % 4));
            if (c >= 2) begin
                chk("t2_rv", 64'(resp_valid), 64'(1));
                chk("t2_id", 64'(resp_id), 64'((c - 2) % 4));
            end
        end
        tick(); set_req(3, 0, 0, 0, 0);

        // Write and read of the same address requested together.
        tick(); set_req(0, 1, 1, 9, 7); set_req(1, 1, 0, 9, 0);
        at_neg(); chk("t3_ack0", 64'(ack), 64'b0001);
        tick(); set_req(0, 0, 0, 0, 0);
        at_neg(); chk("t3_ack1", 64'(ack), 64'b0010);
        chk("t3_en", 64'(EnWrite), 64'(1));
        tick(); set_req(1, 0, 0, 0, 0);
        at_neg(); chk("t3_raddr", 64'(read_addr), 64'(9));
        tick();
        at_neg(); chk("t3_id", 64'(resp_id), 64'(1));
        chk("t3_rdata", 64'(resp_rdata), 64'(7));

        // req0 held, req3 arrives once, then pointer wrap.
        tick(); set_req(0, 1, 0, 0, 0);
        at_neg(); chk("t4_ack0", 64'(ack), 64'b0001);
        tick(); set_req(3, 1, 0, 3, 0);
        n_wait = 0; got = 1'b0;
        repeat (3) if (!got) begin
            at_neg(); n_wait++;
            if (ack[3]) got = 1'b1; else tick();
        end
        chk("t4_req3_acked", 64'(got), 64'(1));
        tick(); set_req(3, 0, 0, 0, 0); set_req(2, 1, 0, 2, 0);
        at_neg(); chk("t4_wrap", 64'(ack), 64'b0001);
        tick();
        at_neg(); chk("t4_next", 64'(ack), 64'b0100);
        tick(); set_req(2, 0, 0, 0, 0);
        at_neg(); chk("t4_back0", 64'(ack), 64'b0001);
        tick(); set_req(0, 0, 0, 0, 0);

        // Reset during a write's stage cycle.
        tick(); set_req(1, 1, 1, 20, 32'h1234);
        at_neg(); chk("t5_ack", 64'(ack), 64'b0010);
        tick(); set_req(1, 0, 0, 0, 0);
        chk("t5_en_before", 64'(EnWrite), 64'(1));
        #1 rst_n = 1'b0;
        #1 chk("t5_en_async", 64'(EnWrite), 64'(0));
        chk("t5_rv", 64'(resp_valid), 64'(0));
        tick();
        chk("t5_mem_kept", 64'(mem[20]), 64'(0));
        rst_n = 1'b1;
        tick(); set_req(1, 1, 0, 20, 0); set_req(3, 1, 0, 3, 0);
        at_neg(); chk("t5_first_grant", 64'(ack), 64'b0010);
        tick(); set_req(1, 0, 0, 0, 0);
        at_neg(); chk("t5_second", 64'(ack), 64'b1000);
        tick(); set_req(3, 0, 0, 0, 0);
        tick(); set_req(1, 1, 0, 1, 0);
        at_neg(); chk("t5_ack1", 64'(ack), 64'b0010);
        tick(); set_req(1, 0, 0, 0, 0);

        // Idle: nothing moves and the pointer holds.
        for (int c = 0; c < 10; c++) begin
            at_neg();
            chk("t6_ack", 64'(ack), 64'(0));
            chk("t6_en", 64'(EnWrite), 64'(0));
            if (c >= 2) chk("t6_rv", 64'(resp_valid), 64'(0));
            tick();
        end
        for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'(i), 0);
        at_neg(); chk("t6_ptr_held", 64'(ack), 64'b0100);
        drain();

        // Random traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            at_neg(); a_seen = ack;
            tick();
            for (int i = 0; i < N; i++) begin
                if (!(req[i] && !a_seen[i])) begin
                    if ($urandom_range(0, 99) < 60)
                        set_req(i, 1, 1'($urandom_range(0, 1)),
                                ($urandom_range(0, 4) == 0) ? AW'($urandom_range(0, 63))
                                                            : AW'($urandom_range(0, 7)),
                                $urandom);
                    else
                        set_req(i, 0, 0, 0, 0);
                end
            end
        end
        drain();
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-write/single-read-port Memory between NUM_REQ requesters, such as several FU_MEM instances or an FU_MEM plus a test/DMA port. It arbitrates round-robin and accepts one request per cycle. Accepted requests pass through a one-entry access stage that drives the Memory ports. Read data returns in order with a requester tag.

Parameters:
SIZE, 32, data word width (matches Memory/registers)
MEM_ROWS, 64, Memory depth; AW = $clog2(MEM_ROWS)
NUM_REQ, 4, number of requesters (≥2); IW = $clog2(NUM_REQ)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester request, held with its fields until ack
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  [NUM_REQ][AW]  word address
req_wdata  in  [NUM_REQ][SIZE]  write data
ack  out  NUM_REQ  one-hot, combinational; request accepted this cycle
resp_valid  out  1  read data valid (one-cycle pulse per read)
resp_id  out  IW  requester index of the returned read
resp_rdata  out  SIZE  read data
EnWrite  out  1  to Memory write enable
write_addr  out  AW  to Memory
write_data  out  SIZE  to Memory
read_addr  out  AW  to Memory
read_data  in  SIZE  from Memory; the read port is combinational

Behaviour:
- Reset (async assert, sync release): rr_ptr=0, stage_valid=0, resp_valid=0, resp_id=0, resp_rdata=0. EnWrite=0, write_addr/write_data/read_addr=0. ack=0 while rst_n=0.
- Arbitration (cycle N, combinational): scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ. The first i with req[i]=1 wins and ack[i]=1; all other ack are 0. No req means no ack.
- On posedge after a grant to i: rr_ptr <= (i+1) mod NUM_REQ, stage <= {valid=1, we, addr, wdata, id=i}. With no grant, stage_valid <= 0 and rr_ptr holds.
- Requester protocol: req and its fields are stable from assertion until the ack cycle. req may drop at the posedge ending the ack cycle. Dropping req before ack is a protocol error; the verification assertion must flag it.
- Access stage (cycle N+1):
  - if stage_valid & we: EnWrite=1, write_addr=stage.addr, write_data=stage.wdata. The write commits at the end of N+1.
  - if stage_valid & ~we: read_addr=stage.addr and EnWrite=0.
  - otherwise EnWrite=0 and the address/data outputs are 0.
- Response (cycle N+2): for a read in the stage, resp_valid=1, resp_id=stage.id, resp_rdata=read_data sampled at the end of N+1. Otherwise resp_valid=0, and resp_id/resp_rdata hold their last values.
- Latency: ack in N, write visible in Memory from N+2, read data in N+2. Throughput is 1 request/cycle, with no bubbles between back-to-back grants.
- Ordering: strictly in-order. A read granted the cycle after a write to the same address returns the new data, because the write commits at the end of its stage cycle and the read samples one cycle later.
- Fairness: with all requesters continuously asserting, grants rotate 0,1,…,NUM_REQ-1,0. Maximum wait is NUM_REQ-1 cycles.
- Single active requester: granted every cycle.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-operation: any staged write is dropped (EnWrite deasserts immediately), and a pending response is lost. The next request after release is arbitrated from index 0.
- addr ≥ MEM_ROWS cannot occur, since AW bits cover exactly MEM_ROWS when it is a power of two. A non-power-of-two MEM_ROWS is unsupported and caught by an elaboration check.

Decomposition:
- Shared package mem_arb_pkg: typedef mem_req_t {we, addr[AW], wdata[SIZE], id[IW]}, plus localparams AW and IW derived from MEM_ROWS and NUM_REQ.
- One sub-module, rr_arbiter: req vector + rr_ptr in, one-hot grant + encoded index out. It is purely combinational and reusable by a future register-write-port arbiter for registers_wp2.

Test Plan:
- Single write then read, requester 2: write addr 5 = 0xDEADBEEF, then read addr 5 → ack[2] in cycles 0 and 1, EnWrite=1 in cycle 1, resp_valid=1, resp_id=2, resp_rdata=0xDEADBEEF in cycle 3.
- All four requesters read addrs 0–3 continuously from reset → ack order 0,1,2,3,0; resp_id sequence 0,1,2,3 in consecutive cycles starting 2 cycles after the first ack.
- Back-to-back RAW: req0 writes addr 9 = 7 while req1 reads addr 9 in the same cycle → req0 acked first; req1's read returns 7, not the old value.
- Fairness under contention: req0 always asserted, req3 asserts once → req3 is acked within 3 cycles, and rr_ptr wraps 3→0.
- Reset mid-write: rst_n dropped during a write's stage cycle → EnWrite falls asynchronously, Memory addr unchanged, resp_valid=0, first post-reset grant goes to the lowest requesting index.
- Idle: no req for 10 cycles → ack=0, EnWrite=0, resp_valid=0, rr_ptr unchanged.
